// File: rtl/esp_io_ctrl_if.sv
// Bus bundle between the Z80 I/O side, the ESP link and esp_io_ctrl.
//
// Handshakes:
//   - TX link (valid/ready): a word moves when tx_valid && tx_ready are both
//     high at the rising clock edge. While tx_valid is high and tx_ready is
//     low, tx_data holds steady. tx_valid never waits for tx_ready.
//   - RX link: rx_valid is a one-cycle push strobe with no back-pressure.
//   - I/O: io_wren and io_rden are one-cycle strobes qualified by io_addr.
//     io_rddata is combinational from io_addr.
interface esp_io_ctrl_if;
  logic [7:0] io_addr;
  logic [7:0] io_wrdata;
  logic       io_wren;
  logic       io_rden;
  logic [7:0] io_rddata;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  // Driver side: the Z80 host and the ESP link together.
  modport master (
    output io_addr, io_wrdata, io_wren, io_rden, tx_ready, rx_data, rx_valid,
    input  io_rddata, tx_data, tx_valid
  );

  // Controller side.
  modport slave (
    input  io_addr, io_wrdata, io_wren, io_rden, tx_ready, rx_data, rx_valid,
    output io_rddata, tx_data, tx_valid
  );
endinterface

// File: rtl/esp_io_ctrl.sv
// ESP I/O controller: a Z80 I/O port pair (F4 = STATUS/control,
// F5 = DATA) bridging an RX byte FIFO (ESP -> Z80) and a TX FIFO
// (Z80 -> ESP). Each TX word carries a start-of-frame flag in bit 8.
module esp_io_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  esp_io_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [7:0] ADDR_STATUS = 8'hF4;
  localparam logic [7:0] ADDR_DATA   = 8'hF5;

  // FIFO storage is not reset; pointers and counts alone define validity.
  logic [7:0] rx_mem [DEPTH];
  logic [8:0] tx_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CNT_W-1:0]      rx_count_q, rx_count_d, tx_count_q, tx_count_d;
  logic                  sof_pend_q, sof_pend_d;
  logic                  rx_ovf_q, rx_ovf_d;

  logic sel_status, sel_data;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_pop, rx_push, rx_drop, rx_flush, ovf_clr, tx_pop, tx_push;

  assign sel_status = (bus.io_addr == ADDR_STATUS);
  assign sel_data   = (bus.io_addr == ADDR_DATA);
  assign rx_empty   = (rx_count_q == '0);
  assign rx_full    = (rx_count_q == CNT_FULL);
  assign tx_empty   = (tx_count_q == '0);
  assign tx_full    = (tx_count_q == CNT_FULL);

  // Decode strobes into FIFO events; a pop frees the slot a same-cycle push needs.
  always_comb begin
    rx_flush = bus.io_wren && sel_status && bus.io_wrdata[7];
    ovf_clr  = bus.io_wren && sel_status && (bus.io_wrdata[7] || bus.io_wrdata[2]);
    rx_pop   = bus.io_rden && sel_data && !rx_empty;
    rx_push  = bus.rx_valid && !rx_flush && (!rx_full || rx_pop);
    rx_drop  = bus.rx_valid && !rx_flush && rx_full && !rx_pop;
    tx_pop   = !tx_empty && bus.tx_ready;
    tx_push  = bus.io_wren && sel_data && (!tx_full || tx_pop);
  end

  // Next-state for pointers, counts and flags.
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q + DEPTH_LOG2'(rx_push);
    rx_rd_ptr_d = rx_rd_ptr_q + DEPTH_LOG2'(rx_pop);
    rx_count_d  = rx_count_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    tx_wr_ptr_d = tx_wr_ptr_q + DEPTH_LOG2'(tx_push);
    tx_rd_ptr_d = tx_rd_ptr_q + DEPTH_LOG2'(tx_pop);
    tx_count_d  = tx_count_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    sof_pend_d  = sof_pend_q;
    rx_ovf_d    = rx_ovf_q;

    // Flush empties RX by catching the read pointer up to the write pointer.
    if (rx_flush) begin
      rx_rd_ptr_d = rx_wr_ptr_q;
      rx_count_d  = '0;
      sof_pend_d  = 1'b1;
    end
    if (tx_push) begin
      sof_pend_d = 1'b0;
    end
    // A drop in the same cycle as a plain clear still records the overflow.
    if (ovf_clr) begin
      rx_ovf_d = 1'b0;
    end
    if (rx_drop) begin
      rx_ovf_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      sof_pend_q  <= 1'b0;
      rx_ovf_q    <= 1'b0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      sof_pend_q  <= sof_pend_d;
      rx_ovf_q    <= rx_ovf_d;
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr_q] <= bus.rx_data;
    end
    if (tx_push) begin
      tx_mem[tx_wr_ptr_q] <= {sof_pend_q, bus.io_wrdata};
    end
  end

  // I/O read mux: STATUS flags, RX head, or zero for undecoded addresses.
  always_comb begin
    bus.io_rddata = 8'h00;
    if (sel_status) begin
      bus.io_rddata = {5'b0, rx_ovf_q, tx_full, !rx_empty};
    end else if (sel_data && !rx_empty) begin
      bus.io_rddata = rx_mem[rx_rd_ptr_q];
    end
  end

  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_empty ? 9'h000 : tx_mem[tx_rd_ptr_q];
endmodule

// File: tb/tb_esp_io_ctrl.sv
// Bench for esp_io_ctrl: directed scenarios plus a random run, all checked
// against a queue-based reference model of the two FIFOs and flags.
module tb_esp_io_ctrl;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int errors = 0;
  int checks = 0;

  esp_io_ctrl_if bus();

  esp_io_ctrl #(.DEPTH_LOG2(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference model.
  logic [7:0] rx_q[$];
  logic [8:0] exp_q[$];
  logic       sof_m;
  logic       ovf_m;

  task automatic model_clear();
    rx_q.delete();
    exp_q.delete();
    sof_m = 1'b0;
    ovf_m = 1'b0;
  endtask

  // Apply one clock's worth of the current inputs to the model.
  task automatic model_step();
    int  rx_n;
    int  tx_n;
    bit  tx_pop;
    bit  rx_pop;
    bit  flush;
    rx_n   = rx_q.size();
    tx_n   = exp_q.size();
    rx_pop = 1'b0;
    flush  = 1'b0;
    tx_pop = (tx_n > 0) && bus.tx_ready;
    if (tx_pop) void'(exp_q.pop_front());
    if (bus.io_wren && bus.io_addr == 8'hF5 && (tx_n < DEPTH || tx_pop)) begin
      exp_q.push_back({sof_m, bus.io_wrdata});
      sof_m = 1'b0;
    end
    if (bus.io_wren && bus.io_addr == 8'hF4) begin
      if (bus.io_wrdata[7]) begin
        flush = 1'b1;
        sof_m = 1'b1;
        rx_q.delete();
        ovf_m = 1'b0;
      end
      if (bus.io_wrdata[2]) ovf_m = 1'b0;
    end
    if (bus.io_rden && bus.io_addr == 8'hF5 && rx_n > 0) begin
      void'(rx_q.pop_front());
      rx_pop = 1'b1;
    end
    if (bus.rx_valid && !flush) begin
      if (rx_n < DEPTH || rx_pop) rx_q.push_back(bus.rx_data);
      else ovf_m = 1'b1;
    end
  endtask

  function automatic logic [7:0] exp_rddata(input logic [7:0] a);
    if (a == 8'hF4) return {5'b0, ovf_m, exp_q.size() == DEPTH, rx_q.size() != 0};
    if (a == 8'hF5) return (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    return 8'h00;
  endfunction

  // Driver tasks.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    bus.io_wren  = 1'b0;
    bus.io_rden  = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    bus.io_addr   = a;
    bus.io_wrdata = d;
    bus.io_wren   = 1'b1;
    cycle();
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d);
    bus.io_addr = a;
    bus.io_rden = 1'b1;
    #1;
    d = bus.io_rddata;
    cycle();
  endtask

  task automatic rx_send(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    cycle();
  endtask

  task automatic peek_status(output logic [7:0] d);
    bus.io_addr = 8'hF4;
    #1;
    d = bus.io_rddata;
  endtask

  // Scenarios.
  task automatic test_reset();
    logic [7:0] d;
    #1 reset_n = 1'b0;
    bus.rx_valid  = 1'b1;
    bus.rx_data   = 8'h3C;
    bus.io_addr   = 8'hF5;
    bus.io_wrdata = 8'h11;
    bus.io_wren   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); errors++;
    end
    bus.io_wren = 1'b0;
    peek_status(d);
    checks++;
    if (d !== 8'h00) begin
      $display("FAIL reset_status: got %h want 00", d); errors++;
    end
    bus.rx_valid = 1'b0;
    model_clear();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    peek_status(d);
    checks++;
    if (d !== exp_rddata(8'hF4)) begin
      $display("FAIL post_reset_status: got %h want %h", d, exp_rddata(8'hF4)); errors++;
    end
    io_read(8'hF5, d);
    checks++;
    if (d !== 8'h00) begin
      $display("FAIL post_reset_data: got %h want 00", d); errors++;
    end
  endtask

  task automatic test_frame_send();
    bus.tx_ready = 1'b1;
    io_write(8'hF4, 8'h80);
    io_write(8'hF5, 8'h10);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 9'h110) begin
      $display("FAIL frame_first: got v=%b d=%h want v=1 d=110", bus.tx_valid, bus.tx_data);
      errors++;
    end
    io_write(8'hF5, 8'h00);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 9'h000) begin
      $display("FAIL frame_second: got v=%b d=%h want v=1 d=000", bus.tx_valid, bus.tx_data);
      errors++;
    end
    cycle();
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      $display("FAIL frame_drained: got v=%b want 0", bus.tx_valid); errors++;
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_rx_overflow();
    logic [7:0] d;
    for (int i = 0; i < 17; i++) rx_send(8'(i));
    peek_status(d);
    checks++;
    if (d !== 8'h05) begin
      $display("FAIL ovf_status: got %h want 05", d); errors++;
    end
    for (int i = 0; i < 16; i++) begin
      io_read(8'hF5, d);
      checks++;
      if (d !== 8'(i)) begin
        $display("FAIL ovf_read%0d: got %h want %h", i, d, 8'(i)); errors++;
      end
    end
    peek_status(d);
    checks++;
    if (d !== 8'h04) begin
      $display("FAIL ovf_sticky: got %h want 04", d); errors++;
    end
    io_write(8'hF4, 8'h04);
    peek_status(d);
    checks++;
    if (d !== 8'h00) begin
      $display("FAIL ovf_clear: got %h want 00", d); errors++;
    end
  endtask

  task automatic test_tx_full_drop();
    logic [7:0] d;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) io_write(8'hF5, 8'(i));
    peek_status(d);
    checks++;
    if (d !== 8'h02) begin
      $display("FAIL txfull_status: got %h want 02", d); errors++;
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 9'h000) begin
        $display("FAIL txfull_hold%0d: got v=%b d=%h want v=1 d=000", k, bus.tx_valid, bus.tx_data);
        errors++;
      end
    end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 9'(i)) begin
        $display("FAIL txfull_drain%0d: got v=%b d=%h want v=1 d=%h", i, bus.tx_valid, bus.tx_data, 9'(i));
        errors++;
      end
      cycle();
    end
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      $display("FAIL txfull_empty: got v=%b want 0 (byte 16 present)", bus.tx_valid); errors++;
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_tx_full_concurrent();
    logic [7:0] d;
    logic [8:0] last;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) io_write(8'hF5, 8'h20 + 8'(i));
    bus.tx_ready = 1'b1;
    io_write(8'hF5, 8'h77);
    bus.tx_ready = 1'b0;
    peek_status(d);
    checks++;
    if (d !== 8'h02 || bus.tx_data !== 9'h021) begin
      $display("FAIL txconc_state: got st=%h d=%h want st=02 d=021", d, bus.tx_data); errors++;
    end
    bus.tx_ready = 1'b1;
    last = 9'h1FF;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      checks++;
      if (bus.tx_data !== exp_q[0]) begin
        $display("FAIL txconc_drain%0d: got %h want %h", i, bus.tx_data, exp_q[0]); errors++;
      end
      last = bus.tx_data;
      cycle();
    end
    checks++;
    if (last !== 9'h077 || bus.tx_valid !== 1'b0) begin
      $display("FAIL txconc_last: got last=%h v=%b want last=077 v=0", last, bus.tx_valid); errors++;
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_flush_push();
    logic [7:0] d;
    rx_send(8'h01);
    rx_send(8'h02);
    rx_send(8'h03);
    bus.io_addr   = 8'hF4;
    bus.io_wrdata = 8'h80;
    bus.io_wren   = 1'b1;
    bus.rx_valid  = 1'b1;
    bus.rx_data   = 8'hAA;
    cycle();
    peek_status(d);
    checks++;
    if (d !== 8'h00) begin
      $display("FAIL flush_status: got %h want 00", d); errors++;
    end
    io_read(8'hF5, d);
    checks++;
    if (d !== 8'h00) begin
      $display("FAIL flush_data: got %h want 00", d); errors++;
    end
    io_write(8'hF5, 8'h5A);
    checks++;
    if (bus.tx_data !== 9'h15A) begin
      $display("FAIL flush_sof: got %h want 15A", bus.tx_data); errors++;
    end
    bus.tx_ready = 1'b1;
    cycle();
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_full_boundary();
    logic [7:0] d;
    for (int i = 0; i < 16; i++) rx_send(8'h10 + 8'(i));
    bus.io_addr  = 8'hF5;
    bus.io_rden  = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    #1;
    d = bus.io_rddata;
    cycle();
    checks++;
    if (d !== 8'h10) begin
      $display("FAIL bound_head: got %h want 10", d); errors++;
    end
    peek_status(d);
    checks++;
    if (d !== 8'h01) begin
      $display("FAIL bound_status: got %h want 01", d); errors++;
    end
    for (int i = 0; i < 16; i++) begin
      io_read(8'hF5, d);
      checks++;
      if (d !== ((i < 15) ? 8'h11 + 8'(i) : 8'h55)) begin
        $display("FAIL bound_read%0d: got %h want %h", i, d, (i < 15) ? 8'h11 + 8'(i) : 8'h55);
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_send(8'h30 + 8'(i));
      io_write(8'hF5, 8'h40 + 8'(i));
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      $display("FAIL rstmid_tx_valid: got %b want 0", bus.tx_valid); errors++;
    end
    peek_status(d);
    checks++;
    if (d !== 8'h00) begin
      $display("FAIL rstmid_status: got %h want 00", d); errors++;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    model_clear();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    peek_status(d);
    checks++;
    if (d !== 8'h00 || bus.tx_valid !== 1'b0) begin
      $display("FAIL rstmid_after: got st=%h v=%b want st=00 v=0", d, bus.tx_valid); errors++;
    end
    rx_send(8'h99);
    io_read(8'hF5, d);
    checks++;
    if (d !== 8'h99) begin
      $display("FAIL rstmid_latency: got %h want 99", d); errors++;
    end
  endtask

  task automatic test_random();
    int sel;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      bus.io_addr   = (sel < 2) ? 8'hF4 : (sel < 8) ? 8'hF5 : 8'($urandom_range(0, 255));
      bus.io_wrdata = 8'($urandom);
      if (bus.io_addr == 8'hF4 && $urandom_range(0, 3) != 0) bus.io_wrdata[7] = 1'b0;
      bus.io_wren   = ($urandom_range(0, 2) == 0);
      bus.io_rden   = ($urandom_range(0, 2) == 0);
      bus.rx_valid  = ($urandom_range(0, 1) == 1);
      bus.rx_data   = 8'($urandom);
      bus.tx_ready  = ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (bus.io_rddata !== exp_rddata(bus.io_addr)) begin
        $display("FAIL rand_rddata%0d: addr=%h got %h want %h", n, bus.io_addr, bus.io_rddata,
                 exp_rddata(bus.io_addr));
        errors++;
      end
      checks++;
      if (bus.tx_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && bus.tx_data !== exp_q[0])) begin
        $display("FAIL rand_tx%0d: got v=%b d=%h want v=%b d=%h", n, bus.tx_valid, bus.tx_data,
                 exp_q.size() != 0, (exp_q.size() != 0) ? exp_q[0] : 9'h000);
        errors++;
      end
      cycle();
    end
    bus.tx_ready = 1'b0;
  endtask

  // Sequencer and final report.
  initial begin
    bus.io_addr   = 8'h00;
    bus.io_wrdata = 8'h00;
    bus.io_wren   = 1'b0;
    bus.io_rden   = 1'b0;
    bus.tx_ready  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    model_clear();
    test_reset();
    test_frame_send();
    test_rx_overflow();
    test_tx_full_drop();
    test_tx_full_concurrent();
    test_flush_push();
    test_full_boundary();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/esp_io_ctrl.md
ESP_IO_CTRL -- requirements
Module: esp_io_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: log2 of the entry count of each FIFO (RX and TX both hold 16 entries by default).
REQ-002 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 io_addr  in  8  Z80 I/O port address; only 8'hF4 (STATUS) and 8'hF5 (DATA) are decoded.
REQ-005 io_wrdata  in  8  Z80 I/O write data.
REQ-006 io_wren  in  1  one-cycle I/O write strobe.
REQ-007 io_rden  in  1  one-cycle I/O read strobe.
REQ-008 io_rddata  out  8  I/O read data; combinational from io_addr and current state.
REQ-009 tx_data  out  9  head of TX FIFO to ESP link; bit 8 = start-of-frame (SOF), bits 7:0 = byte.
REQ-010 tx_valid  out  1  TX FIFO not empty.
REQ-011 tx_ready  in  1  ESP link accepts tx_data when tx_valid && tx_ready.
REQ-012 rx_data  in  8  byte from ESP link.
REQ-013 rx_valid  in  1  one-cycle push strobe for rx_data; no back-pressure.

Function
REQ-014 STATUS read (io_addr=F4) SHALL return {5'b0, rx_ovf, tx_full, rx_not_empty}.
REQ-015 DATA read (io_addr=F5) SHALL return the RX FIFO head, or 8'h00 when RX is empty.
REQ-016 io_rden at F5 with RX non-empty SHALL pop one RX entry (effective the next cycle); with RX empty it SHALL change no state.
REQ-017 io_rddata for any other io_addr SHALL be 8'h00, and io_rden there SHALL change no state.
REQ-018 io_wren at F5 with TX not full SHALL push {sof_pend, io_wrdata} and clear sof_pend.
REQ-019 io_wren at F5 with TX full SHALL drop the byte; TX contents and sof_pend SHALL stay unchanged.
REQ-020 io_wren at F4 with io_wrdata[7]=1 SHALL:
  - set sof_pend;
  - flush the RX FIFO (pointers equal, count 0);
  - clear rx_ovf.
REQ-021 io_wren at F4 with io_wrdata[2]=1 SHALL clear rx_ovf; all other F4 write bits SHALL be ignored.
REQ-022 rx_valid with RX not full SHALL push rx_data.
REQ-023 rx_valid with RX full SHALL drop the byte and set rx_ovf (sticky).
REQ-024 RX pop and rx_valid in the same cycle with RX full SHALL both take effect (count unchanged) and SHALL NOT set rx_ovf.
REQ-025 RX flush (REQ-020) and rx_valid in the same cycle: flush wins; the incoming byte SHALL be discarded and rx_ovf SHALL NOT be set.
REQ-026 TX push and tx_valid&&tx_ready in the same cycle SHALL both take effect, including when TX is full.
REQ-027 FIFO pointers SHALL be DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2.
REQ-028 Each FIFO count SHALL be DEPTH_LOG2+1 bits:
  - full = count == 2^DEPTH_LOG2;
  - empty = count == 0.
REQ-029 The TX FIFO SHALL be drained in order only via tx_valid&&tx_ready; tx_data SHALL be stable while tx_valid && !tx_ready.
REQ-030 Latency:
  - a byte pushed by rx_valid SHALL be readable at F5 the following cycle;
  - a byte written to F5 SHALL appear on tx_data the following cycle when TX was empty.

Reset
REQ-031 reset_n low SHALL asynchronously clear all pointers and counts, sof_pend, and rx_ovf.
REQ-032 While reset_n is low: tx_valid=0, STATUS reads 8'h00, and rx_valid and I/O strobes SHALL be ignored.
REQ-033 Reset deasserting mid-frame SHALL leave no residual FIFO data; FIFO RAM contents need no reset.

Verification
REQ-034 Frame send:
  - stimulus: write F4=8'h80, then F5=8'h10, 8'h00, with tx_ready=1;
  - response: tx_data = 9'h110 then 9'h000.
REQ-035 RX overflow:
  - stimulus: 17 rx_valid pushes (bytes 0..16) with no reads;
  - response: STATUS=8'h05; then 16 F5 reads return 0..15; STATUS=8'h04.
REQ-036 TX full drop:
  - stimulus: tx_ready=0, 17 F5 writes (bytes 0..16);
  - response: STATUS bit1=1; byte 16 absent; draining yields 0..15 in order.
REQ-037 Simultaneous flush and push:
  - stimulus: RX holds 3 bytes; F4=8'h80 write coincides with rx_valid=1, rx_data=8'hAA;
  - response: STATUS bit0=0; F5 reads 8'h00.
REQ-038 Full-boundary concurrency:
  - stimulus: RX full, pop and rx_valid=1 (8'h55) in the same cycle;
  - response: rx_ovf stays 0; 8'h55 is read last.
REQ-039 Reset mid-operation:
  - stimulus: both FIFOs half full, pulse reset_n low asynchronously;
  - response: tx_valid=0 immediately; STATUS=8'h00.
